// File: rtl/modular_double_scaler_pkg.sv
// Shared Kyber constants and scaler FSM state encoding.
package modular_double_scaler_pkg;

    localparam int unsigned KYBER_Q            = 3329;
    localparam int unsigned KYBER_DATA_WIDTH   = 12;
    localparam int unsigned SCALER_SHIFT_WIDTH = 3;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } scaler_state_t;

endpackage

// File: rtl/modular_double.sv
// Combinational modular doubling: o_y = (2 * i_a) mod Q, valid for i_a < Q.
module modular_double
    import modular_double_scaler_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = KYBER_DATA_WIDTH,
    parameter int unsigned Q          = KYBER_Q
) (
    input  logic [DATA_WIDTH-1:0] i_a,
    output logic [DATA_WIDTH-1:0] o_y
);

    localparam logic [DATA_WIDTH:0] LP_Q_EXT = (DATA_WIDTH + 1)'(Q);

    logic [DATA_WIDTH:0] w_twice;
    logic [DATA_WIDTH:0] w_reduced;

    // One extra bit holds 2a < 2Q; a single conditional subtract lands in [0, Q).
    always_comb begin
        w_twice   = {i_a, 1'b0};
        w_reduced = (w_twice >= LP_Q_EXT) ? (w_twice - LP_Q_EXT) : w_twice;
        o_y       = DATA_WIDTH'(w_reduced);
    end

endmodule

// File: rtl/modular_double_scaler.sv
// Streaming scaler: out_data = (in_data * 2^in_shift) mod Q, one doubling per clock.
module modular_double_scaler
    import modular_double_scaler_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = KYBER_DATA_WIDTH,
    parameter int unsigned Q           = KYBER_Q,
    parameter int unsigned SHIFT_WIDTH = SCALER_SHIFT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic [SHIFT_WIDTH-1:0] in_shift,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   busy
);

    localparam logic [DATA_WIDTH-1:0]  LP_Q   = DATA_WIDTH'(Q);
    localparam logic [SHIFT_WIDTH-1:0] LP_ONE = SHIFT_WIDTH'(1);

    scaler_state_t          r_state;
    scaler_state_t          w_state_d;
    logic [DATA_WIDTH-1:0]  r_acc;
    logic [DATA_WIDTH-1:0]  w_acc_d;
    logic [SHIFT_WIDTH-1:0] r_cnt;
    logic [SHIFT_WIDTH-1:0] w_cnt_d;
    logic [DATA_WIDTH-1:0]  w_acc_dbl;
    logic [DATA_WIDTH-1:0]  w_in_red;

    // Input is below 2Q, so one subtract gives the canonical residue.
    assign w_in_red = (in_data >= LP_Q) ? (in_data - LP_Q) : in_data;

    modular_double #(
        .DATA_WIDTH (DATA_WIDTH),
        .Q          (Q)
    ) u_dbl (
        .i_a (r_acc),
        .o_y (w_acc_dbl)
    );

    // State, accumulator and remaining-doubling counter; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_acc   <= w_acc_d;
            r_cnt   <= w_cnt_d;
        end
    end

    // Next-state logic: accept in IDLE, double in RUN, hold result in DONE.
    always_comb begin
        w_state_d = r_state;
        w_acc_d   = r_acc;
        w_cnt_d   = r_cnt;
        case (r_state)
            StIdle: begin
                if (in_valid) begin
                    w_acc_d   = w_in_red;
                    w_cnt_d   = in_shift;
                    w_state_d = (in_shift == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                w_acc_d = w_acc_dbl;
                w_cnt_d = r_cnt - LP_ONE;
                if (r_cnt == LP_ONE) begin
                    w_state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    w_state_d = StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    assign in_ready  = (r_state == StIdle);
    assign out_valid = (r_state == StDone);
    assign busy      = (r_state != StIdle);
    // acc is untouched outside RUN/accept, so the last result persists after handshake.
    assign out_data  = r_acc;

endmodule

// File: tb/tb_modular_double_scaler.sv
// Self-checking bench for modular_double_scaler: directed cases plus a random sweep.
module tb_modular_double_scaler;

    localparam int QM = 3329;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_data;
    logic [2:0]  in_shift;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_data;
    logic        busy;

    int checks = 0;
    int errors = 0;

    modular_double_scaler dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shift  (in_shift),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference: plain modular arithmetic on integers.
    function automatic int ref_scale(input int x, input int k);
        return (x * (1 << k)) % QM;
    endfunction

    // Modular halving (inverse of doubling) used for the round-trip property.
    function automatic int ref_halve(input int a);
        return (a % 2 == 0) ? a / 2 : (a + QM) / 2;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One complete job: accept, wait for result, optional back-pressure, handshake.
    // lat counts clock edges after the accept edge until out_valid is seen.
    task automatic run_job(input int x, input int k, input int exp, input int stall,
                           input bit compete, input string tag, output int got);
        int  n;
        bit  seen;
        out_ready = 1'b0;
        in_data   = x[11:0];
        in_shift  = k[2:0];
        in_valid  = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, ":in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        // Scramble inputs after the accept edge; they must not affect the job.
        in_valid = 1'b0;
        in_data  = 12'($urandom);
        in_shift = 3'($urandom);
        seen = 1'b0;
        n    = 0;
        for (int c = 0; c <= 20; c++) begin
            if (out_valid) begin
                seen = 1'b1;
                n    = c;
                break;
            end
            if (stall == 0) out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        check({tag, ":valid_seen"}, 32'(seen), 32'd1);
        check({tag, ":latency"}, 32'(n), 32'(k));
        got = int'(out_data);
        check({tag, ":data"}, 32'(out_data), 32'(exp));
        for (int s = 0; s < stall; s++) begin
            in_valid = compete;
            in_data  = 12'd9;
            in_shift = 3'd1;
            @(posedge clk); #1;
            check({tag, ":hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, ":hold_data"}, 32'(out_data), 32'(exp));
            check({tag, ":hold_in_ready"}, 32'(in_ready), 32'd0);
            check({tag, ":hold_busy"}, 32'(busy), 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, ":post_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, ":post_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, ":post_busy"}, 32'(busy), 32'd0);
        check({tag, ":post_data_kept"}, 32'(out_data), 32'(exp));
    endtask

    initial begin
        int got;
        int x;
        int k;
        int r;
        bit saw;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shift  = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("reset:out_valid", 32'(out_valid), 32'd0);
        check("reset:out_data", 32'(out_data), 32'd0);
        check("reset:busy", 32'(busy), 32'd0);
        check("reset:in_ready", 32'(in_ready), 32'd1);

        run_job(1665, 1, 1, 0, 1'b0, "x1665k1", got);
        run_job(3000, 3, 697, 0, 1'b0, "x3000k3", got);
        run_job(1, 7, 128, 0, 1'b0, "x1k7", got);
        run_job(4000, 0, 671, 0, 1'b0, "x4000k0", got);
        run_job(3328, 1, 3327, 0, 1'b0, "x3328k1", got);
        run_job(0, 5, 0, 0, 1'b0, "x0k5", got);

        // Back-pressure with a competing request that must be ignored.
        run_job(7, 2, 28, 5, 1'b1, "bp_x7k2", got);
        run_job(9, 1, 18, 0, 1'b0, "after_bp_x9k1", got);

        // Reset in the middle of a long job.
        in_data  = 12'd5;
        in_shift = 3'd7;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("midrst:busy_before", 32'(busy), 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst:out_valid", 32'(out_valid), 32'd0);
        check("midrst:busy", 32'(busy), 32'd0);
        check("midrst:in_ready", 32'(in_ready), 32'd1);
        check("midrst:out_data", 32'(out_data), 32'd0);
        saw = 1'b0;
        out_ready = 1'b1;
        repeat (12) begin
            @(posedge clk); #1;
            saw = saw | out_valid;
        end
        out_ready = 1'b0;
        check("midrst:no_stale", 32'(saw), 32'd0);
        run_job(2, 2, 8, 0, 1'b0, "after_rst_x2k2", got);

        // Random sweep against the model, plus a halving round trip.
        for (int j = 0; j < 2000; j++) begin
            x = int'($urandom_range(0, 4095));
            k = int'($urandom_range(0, 7));
            run_job(x, k, ref_scale(x, k), int'($urandom_range(0, 2)), 1'($urandom),
                    "rand", got);
            r = got;
            for (int h = 0; h < k; h++) r = ref_halve(r);
            check("rand:roundtrip", 32'(r), 32'(x % QM));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
